lcd_bus_reader_8: RTL and testbench
===================================

Name: lcd_bus_reader_8

Overview:
- Read-side engine for the SC1602 (HD44780-compatible) 8-bit parallel LCD bus. It is the complement of the existing write driver (lcd_driver_8).
- Issues RW=1 bus cycles to read either the busy flag/address counter (RS=0) or DDRAM/CGRAM data (RS=1).
- Returns the sampled byte on a valid/ready request interface.
- Sits beside the write driver on the same LCD pins. Top-level muxing gives bus ownership to one engine at a time.

Parameters:
- SETUP_CYC, 2: cycles RS/RW are stable before E rises (tAS ≥ 60 ns at 27 MHz).
- EN_HIGH_CYC, 13: cycles E is held high (PWEH ≥ 450 ns). DB is sampled on the last of these cycles.
- HOLD_CYC, 1: cycles RS/RW are held after E falls (tAH).
- CYCLE_MIN_CYC, 27: minimum cycles from SETUP entry to next SETUP entry or IDLE (tcycE ≥ 1000 ns).
- POLL_MAX, 255: maximum busy-flag reads per poll request. Used only with LCD_BUSY_POLL_EN.

Ports:
- sys_clk, in, 1: single clock, 27 MHz nominal.
- sys_rst_n, in, 1: reset. Asynchronous, active-low.
- rd_req, in, 1: read request. Accepted only in the cycle rd_ready=1.
- rd_rs, in, 1: register select for the request. 0 = busy flag/AC, 1 = data.
- rd_ready, out, 1: engine idle and able to accept a request.
- rd_valid, out, 1: one-cycle pulse; rd_data is valid.
- rd_data, out, 8: byte captured from the LCD bus.
- lcd_en, out, 1: LCD E strobe.
- lcd_rs, out, 1: LCD RS.
- lcd_rw, out, 1: LCD R/W (1 = read).
- lcd_db_in, in, 8: LCD DB[7:0] input. This block never drives DB.
- rd_poll, in, 1: present only with LCD_BUSY_POLL_EN. Requests a busy-wait read.
- rd_timeout, out, 1: present only with LCD_BUSY_POLL_EN. Qualifies rd_valid; indicates POLL_MAX was exhausted.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - lcd_en=0, lcd_rs=0, lcd_rw=0, rd_valid=0, rd_data=8'h00, rd_timeout=0, rd_ready=1, state=IDLE.
  - Reset asserted mid-cycle drops E at once; no partial result is reported.
- States: IDLE → SETUP → EN_HIGH → HOLD → GAP → IDLE (or → SETUP when polling).
- IDLE:
  - rd_ready=1, lcd_en=0, lcd_rw=0, lcd_rs=0.
  - rd_req=1 latches rd_rs and moves to SETUP next cycle.
  - rd_ready is registered from the state, so it falls the cycle after acceptance.
- SETUP: lcd_rw=1, lcd_rs=latched rs, lcd_en=0, held for SETUP_CYC cycles.
- EN_HIGH:
  - lcd_en=1 for EN_HIGH_CYC cycles.
  - On the final EN_HIGH cycle, lcd_db_in is registered into a capture register.
- HOLD:
  - lcd_en=0 while RS/RW are held, for HOLD_CYC cycles.
  - rd_valid pulses for 1 cycle at HOLD entry, with rd_data = captured byte.
- GAP:
  - lcd_en=0, RS/RW held.
  - Waits until the cycle counter reaches CYCLE_MIN_CYC, counted from SETUP entry.
  - If SETUP_CYC+EN_HIGH_CYC+HOLD_CYC ≥ CYCLE_MIN_CYC, GAP lasts 0 cycles.
- Latency, req accepted to rd_valid: 1+SETUP_CYC+EN_HIGH_CYC cycles (16 at defaults). Engine returns to IDLE CYCLE_MIN_CYC+1 cycles after acceptance.
- Handshake rules:
  - rd_req while rd_ready=0 is ignored; there is no queue.
  - rd_rs changes after acceptance have no effect.
- Counters:
  - Counter width is $clog2(max(CYCLE_MIN_CYC, POLL_MAX)+1).
  - Counters saturate and never wrap.
  - Every parameter must be ≥ 1; a value of 0 is illegal and caught by an elaboration check.
- rd_data holds its value until the next rd_valid.

Optional Feature:
- LCD_BUSY_POLL_EN defined:
  - rd_poll and rd_timeout exist.
  - A request with rd_poll=1 forces RS=0 and repeats reads until captured bit 7 (BF) = 0 or POLL_MAX reads have been done.
  - Between reads the engine goes GAP → SETUP directly, without visiting IDLE.
  - rd_valid pulses only on the final read. rd_timeout=1 with that pulse iff BF was still 1 on read number POLL_MAX.
  - rd_poll=0 gives single-read behaviour.
- LCD_BUSY_POLL_EN undefined: rd_poll and rd_timeout ports and the poll counter are absent; every request is a single read.

Decomposition:
- Package lcd_pkg holds:
  - state enum;
  - default timing constants (27 MHz);
  - LCD_BF_BIT=7;
  - RS_INSTR=0, RS_DATA=1.
- Single module, no sub-module: the timing counter and FSM are tightly coupled.

Test Plan:
- Reset mid EN_HIGH (sys_rst_n low at cycle 8 of E):
  - lcd_en=0 in the same cycle;
  - rd_valid never pulses;
  - rd_ready=1 after release.
- Single data read: rd_req=1, rd_rs=1, model drives DB=8'h46 while E is high:
  - rd_valid at cycle 16 after acceptance with rd_data=8'h46;
  - E high exactly 13 cycles;
  - RS=1 and RW=1 stable 2 cycles before E rises and 1 cycle after it falls.
- Bus cycle spacing: back-to-back requests (rd_req held at 1):
  - SETUP entries ≥ 28 cycles apart (27 in the engine plus 1 IDLE accept cycle);
  - requests while busy are dropped.
- Sampling edge: DB changes from 8'h00 to 8'hA5 on E-high cycle 12 → rd_data=8'hA5. DB changes on E-high cycle 13 → captured value is the pre-change byte.
- LCD_BUSY_POLL_EN: rd_poll=1, model returns BF=1 for 3 reads, then 8'h05 → exactly 4 E pulses, one rd_valid with rd_data=8'h05, rd_timeout=0.
- LCD_BUSY_POLL_EN, POLL_MAX=4, BF stuck at 1 (DB=8'h80) → 4 E pulses, rd_valid with rd_timeout=1 and rd_data=8'h80, then IDLE.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared state type, 27 MHz timing defaults and bus constants for the SC1602 read engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HIGH,
    ST_HOLD,
    ST_GAP
  } lcd_rd_state_e;

  localparam int LCD_SETUP_CYC     = 2;
  localparam int LCD_EN_HIGH_CYC   = 13;
  localparam int LCD_HOLD_CYC      = 1;
  localparam int LCD_CYCLE_MIN_CYC = 27;
  localparam int LCD_POLL_MAX      = 255;

  localparam int   LCD_BF_BIT = 7;
  localparam logic RS_INSTR   = 1'b0;
  localparam logic RS_DATA    = 1'b1;

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_reader_8.sv
// Read-side engine for the SC1602 8-bit LCD bus: one RW=1 bus cycle per request.
// Define LCD_BUSY_POLL_EN to add rd_poll/rd_timeout and busy-flag polling.
module lcd_bus_reader_8
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = LCD_SETUP_CYC,
  parameter int EN_HIGH_CYC   = LCD_EN_HIGH_CYC,
  parameter int HOLD_CYC      = LCD_HOLD_CYC,
  parameter int CYCLE_MIN_CYC = LCD_CYCLE_MIN_CYC,
  parameter int POLL_MAX      = LCD_POLL_MAX
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rd_req,
  input  logic       rd_rs,
`ifdef LCD_BUSY_POLL_EN
  input  logic       rd_poll,
  output logic       rd_timeout,
`endif
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [7:0] lcd_db_in
);

  localparam int CNT_W = $clog2(lcd_max(CYCLE_MIN_CYC, POLL_MAX) + 1);
  localparam int SE_I  = SETUP_CYC + EN_HIGH_CYC;
  localparam int SEH_I = SE_I + HOLD_CYC;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] EN_END    = CNT_W'(SE_I);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(SEH_I);
  localparam logic [CNT_W-1:0] CYCLE_END = CNT_W'(CYCLE_MIN_CYC);

  if (SETUP_CYC < 1 || EN_HIGH_CYC < 1 || HOLD_CYC < 1 || CYCLE_MIN_CYC < 1 || POLL_MAX < 1)
  begin : g_bad_param
    $error("lcd_bus_reader_8: every timing parameter must be >= 1");
  end
  // The phase boundaries are compared against one saturating counter, so they must fit in it.
  if (SEH_I >= (1 << CNT_W)) begin : g_bad_span
    $error("lcd_bus_reader_8: SETUP+EN_HIGH+HOLD exceeds the cycle counter range");
  end

  lcd_rd_state_e    state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_ready_q, rd_valid_q;
  logic [7:0]       rd_data_q;
  logic             lcd_en_q, lcd_rs_q, lcd_rw_q;
  logic             last_rd;
  logic             bus_done;

  assign cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

  // A bus cycle ends once tcycE is met, counted from SETUP entry; GAP is skipped if already met.
  assign bus_done = ((state_q == ST_HOLD) && (cnt_q == HOLD_END) && (cnt_q >= CYCLE_END)) ||
                    ((state_q == ST_GAP) && (cnt_q >= CYCLE_END));

`ifdef LCD_BUSY_POLL_EN
  localparam logic [CNT_W-1:0] POLL_END = CNT_W'(POLL_MAX);

  logic             poll_q, more_q, timeout_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  assign pcnt_d     = (pcnt_q == CNT_SAT) ? pcnt_q : pcnt_q + CNT_ONE;
  assign last_rd    = !poll_q || !lcd_db_in[LCD_BF_BIT] || (pcnt_q >= POLL_END);
  assign rd_timeout = timeout_q;
`else
  assign last_rd = 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_q     <= 1'b0;
      more_q     <= 1'b0;
      timeout_q  <= 1'b0;
      pcnt_q     <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      cnt_q      <= cnt_d;
      unique case (state_q)
        ST_IDLE: begin
          if (rd_req) begin
            state_q    <= ST_SETUP;
            cnt_q      <= CNT_ONE;
            rd_ready_q <= 1'b0;
            lcd_rw_q   <= 1'b1;
            lcd_rs_q   <= rd_rs;
`ifdef LCD_BUSY_POLL_EN
            poll_q     <= rd_poll;
            pcnt_q     <= CNT_ONE;
            timeout_q  <= 1'b0;
            if (rd_poll) lcd_rs_q <= RS_INSTR;
`endif
          end
        end
        ST_SETUP: begin
          if (cnt_q == SETUP_END) begin
            state_q  <= ST_EN_HIGH;
            lcd_en_q <= 1'b1;
          end
        end
        ST_EN_HIGH: begin
          if (cnt_q == EN_END) begin
            state_q  <= ST_HOLD;
            lcd_en_q <= 1'b0;
            if (last_rd) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= lcd_db_in;
            end
`ifdef LCD_BUSY_POLL_EN
            more_q    <= !last_rd;
            timeout_q <= poll_q && last_rd && lcd_db_in[LCD_BF_BIT];
`endif
          end
        end
        ST_HOLD: begin
          if ((cnt_q == HOLD_END) && !bus_done) state_q <= ST_GAP;
        end
        ST_GAP: ;
        default: state_q <= ST_IDLE;
      endcase

      if (bus_done) begin
`ifdef LCD_BUSY_POLL_EN
        if (more_q) begin
          // Another busy-flag read: RS/RW stay asserted straight into SETUP.
          state_q <= ST_SETUP;
          cnt_q   <= CNT_ONE;
          pcnt_q  <= pcnt_d;
          more_q  <= 1'b0;
        end else begin
          state_q    <= ST_IDLE;
          rd_ready_q <= 1'b1;
          lcd_rw_q   <= 1'b0;
          lcd_rs_q   <= 1'b0;
        end
`else
        state_q    <= ST_IDLE;
        rd_ready_q <= 1'b1;
        lcd_rw_q   <= 1'b0;
        lcd_rs_q   <= 1'b0;
`endif
      end
    end
  end

  assign rd_ready = rd_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign lcd_en   = lcd_en_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = lcd_rw_q;

endmodule

// File: tb/tb_lcd_bus_reader_8.sv
// Scoreboard bench for lcd_bus_reader_8 with an LCD-side model and bus-timing monitor.
`timescale 1ns/1ps
module tb_lcd_bus_reader_8;
  import lcd_pkg::*;

  localparam int SETUP = LCD_SETUP_CYC;
  localparam int EN    = LCD_EN_HIGH_CYC;
  localparam int HOLD  = LCD_HOLD_CYC;
  localparam int CMIN  = LCD_CYCLE_MIN_CYC;
`ifdef LCD_BUSY_POLL_EN
  localparam int PMAX  = 4;
`else
  localparam int PMAX  = LCD_POLL_MAX;
`endif
  localparam int LAT     = 1 + SETUP + EN;
  localparam int BUS_CYC = (SETUP + EN + HOLD > CMIN) ? (SETUP + EN + HOLD) : CMIN;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_rs = 1'b0;
  logic [7:0] lcd_db_in = 8'h00;
  logic       rd_ready, rd_valid, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] rd_data;
`ifdef LCD_BUSY_POLL_EN
  logic       rd_poll = 1'b0;
  logic       rd_timeout;
`endif

  always #5 sys_clk = ~sys_clk;

  lcd_bus_reader_8 #(.POLL_MAX(PMAX)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rd_req    (rd_req),
    .rd_rs     (rd_rs),
`ifdef LCD_BUSY_POLL_EN
    .rd_poll   (rd_poll),
    .rd_timeout(rd_timeout),
`endif
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db_in (lcd_db_in)
  );

  typedef struct {
    logic [7:0] d;
    logic       rs;
    logic       poll;
    logic       to;
    int         np;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_new, e_got;
  logic [7:0] exp_d = 8'h00;
  logic       exp_to = 1'b0;
  int         exp_np = 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: acceptance/readiness model, bus timing, and scoreboard compare on rd_valid.
  int         cyc = 0;
  bit         have_acc = 0, m_ready, poll_now;
  int         acc_cyc = 0, busy_len = 0;
  bit         pr_en = 0, pr_rw = 0, have_setup = 0;
  int         setup_run = 0, e_run = 0, epulse = 0, last_setup = 0;
  logic       rs_at_e = 1'b0;
  logic [7:0] held = 8'h00;

  initial forever begin
    @(negedge sys_clk);
    cyc++;
    if (!sys_rst_n) begin
      sb.delete();
      have_acc = 0; pr_en = 0; pr_rw = 0; have_setup = 0;
      setup_run = 0; e_run = 0; epulse = 0; held = 8'h00;
    end else begin
`ifdef LCD_BUSY_POLL_EN
      poll_now = rd_poll;
`else
      poll_now = 1'b0;
`endif
      m_ready = !have_acc || ((cyc - acc_cyc) >= busy_len);
      chk("rd_ready", rd_ready, m_ready);
      if (m_ready && rd_req) begin
        e_new = '{d: exp_d, rs: (poll_now ? RS_INSTR : rd_rs), poll: poll_now,
                  to: exp_to, np: exp_np, acc: cyc};
        sb.push_back(e_new);
        have_acc = 1; acc_cyc = cyc; busy_len = exp_np * BUS_CYC + 1; epulse = 0;
      end

      if (lcd_rw && !pr_rw) begin
        if (have_setup) chk("setup_spacing_ok", (cyc - last_setup) >= (BUS_CYC + 1), 1);
        have_setup = 1; last_setup = cyc;
      end

      if (lcd_en && !pr_en) begin
        epulse++;
        chk("setup_rw", lcd_rw, 1);
        if (sb.size() > 0) begin
          chk("setup_rs", lcd_rs, sb[0].rs);
          if (sb[0].poll) chk("setup_len_min", setup_run >= SETUP, 1);
          else            chk("setup_len", setup_run, SETUP);
        end else begin
          chk("e_without_request", 1, 0);
        end
        e_run = 1; rs_at_e = lcd_rs;
      end else if (lcd_en) begin
        e_run++;
        chk("rs_stable_e", lcd_rs, rs_at_e);
      end else if (pr_en) begin
        chk("e_high_len", e_run, EN);
        chk("hold_rw", lcd_rw, 1);
        chk("hold_rs", lcd_rs, rs_at_e);
      end
      if (lcd_rw && !lcd_en) setup_run++;
      else                   setup_run = 0;

      if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rd_valid", 1, 0);
        end else begin
          e_got = sb.pop_front();
          chk("rd_data", rd_data, e_got.d);
          chk("e_pulses", epulse, e_got.np);
          if (!e_got.poll) chk("latency", cyc - e_got.acc, LAT);
`ifdef LCD_BUSY_POLL_EN
          chk("rd_timeout", rd_timeout, e_got.to);
`endif
          held = e_got.d;
        end
      end else begin
        chk("rd_data_hold", rd_data, held);
      end
      pr_en = lcd_en; pr_rw = lcd_rw;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge sys_clk); #1;
      n++;
    end while (!(rd_ready && sb.size() == 0) && n < 400);
    if (n >= 400) chk("idle_timeout", 0, 1);
  endtask

  task automatic issue(input logic [7:0] d, input logic rs);
    @(posedge sys_clk); #1;
    lcd_db_in = d; exp_d = d; exp_to = 1'b0; exp_np = 1;
    rd_rs = rs; rd_req = 1'b1;
    @(posedge sys_clk); #1;
    rd_req = 1'b0;
    rd_rs = 1'($urandom);
  endtask

  // Wait until E has been high for k cycles (counted by the bench itself).
  task automatic wait_e_cycles(input int k);
    int run, n;
    run = 0; n = 0;
    while (run < k && n < 200) begin
      @(negedge sys_clk);
      n++;
      if (lcd_en) run++;
    end
    if (run < k) chk("e_wait_timeout", 0, 1);
  endtask

  // DB changes right after the edge closing E-high cycle k; the LCD model's
  // answer is whatever DB shows during the final E-high cycle.
  task automatic sample_test(input int k, input logic [7:0] newv);
    wait_idle();
    @(posedge sys_clk); #1;
    lcd_db_in = 8'h00; exp_d = (k + 1 <= EN) ? newv : 8'h00; exp_to = 1'b0; exp_np = 1;
    rd_rs = 1'b1; rd_req = 1'b1;
    @(posedge sys_clk); #1;
    rd_req = 1'b0;
    wait_e_cycles(k);
    @(posedge sys_clk); #1;
    lcd_db_in = newv;
    wait_idle();
  endtask

`ifdef LCD_BUSY_POLL_EN
  task automatic poll_test(input int busy_reads, input logic [7:0] final_v);
    int falls, n;
    bit prev;
    wait_idle();
    @(posedge sys_clk); #1;
    lcd_db_in = 8'h80;
    exp_np = (busy_reads + 1 <= PMAX) ? busy_reads + 1 : PMAX;
    exp_to = (busy_reads >= PMAX);
    exp_d  = exp_to ? 8'h80 : final_v;
    rd_poll = 1'b1; rd_rs = 1'b1; rd_req = 1'b1;
    @(posedge sys_clk); #1;
    rd_req = 1'b0; rd_poll = 1'b0;
    falls = 0; n = 0; prev = 0;
    while (falls < busy_reads && n < 400) begin
      @(negedge sys_clk);
      n++;
      if (prev && !lcd_en) falls++;
      prev = lcd_en;
    end
    lcd_db_in = final_v;
    wait_idle();
  endtask
`endif

  initial begin
    logic [7:0] d;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_lcd_en", lcd_en, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_ready", rd_ready, 1);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    issue(8'h46, RS_DATA);
    wait_idle();

    sample_test(11, 8'hA5);
    sample_test(13, 8'hA5);

    // rd_req held high with rd_rs toggling: spacing and dropped requests.
    wait_idle();
    d = 8'($urandom);
    @(posedge sys_clk); #1;
    lcd_db_in = d; exp_d = d; exp_to = 1'b0; exp_np = 1; rd_req = 1'b1;
    repeat (90) begin
      @(posedge sys_clk); #1;
      rd_rs = 1'($urandom);
    end
    rd_req = 1'b0;
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      issue(8'($urandom), 1'($urandom));
      repeat ($urandom_range(2, 12)) @(posedge sys_clk);
      #1 rd_req = 1'b1; rd_rs = 1'($urandom);
      @(posedge sys_clk); #1 rd_req = 1'b0;
    end
    wait_idle();

`ifdef LCD_BUSY_POLL_EN
    poll_test(3, 8'h05);
    poll_test(PMAX + 2, 8'h05);
`endif

    // Reset during E high: E drops at once and no result is reported.
    wait_idle();
    @(posedge sys_clk); #1;
    lcd_db_in = 8'h3C; exp_d = 8'h3C; exp_to = 1'b0; exp_np = 1;
    rd_rs = 1'b1; rd_req = 1'b1;
    @(posedge sys_clk); #1;
    rd_req = 1'b0;
    wait_e_cycles(8);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_e_lcd_en", lcd_en, 0);
    chk("rst_mid_e_rd_valid", rd_valid, 0);
    chk("rst_mid_e_rd_data", rd_data, 8'h00);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk); #1;
    chk("ready_after_reset", rd_ready, 1);
    repeat (30) @(posedge sys_clk);

    issue(8'h5A, RS_INSTR);
    wait_idle();
    repeat (5) @(posedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
